// File: rtl/end_screen_controller_if.sv
// Pixel and control bundle between the game/sprite layers and end_screen_controller.
// The master drives game status and colours; the slave returns the final pixel and sequencing flags.
interface end_screen_controller_if;
  logic        new_frame_in;
  logic        game_over_in;
  logic        player_won_in;
  logic        button_in;
  logic [23:0] game_color_in;
  logic [23:0] win_color_in;
  logic [23:0] lose_color_in;
  logic [23:0] color_out;
  logic [1:0]  screen_sel_out;
  logic        game_freeze_out;
  logic        restart_out;

  modport master (
    output new_frame_in, game_over_in, player_won_in, button_in,
    output game_color_in, win_color_in, lose_color_in,
    input  color_out, screen_sel_out, game_freeze_out, restart_out
  );

  modport slave (
    input  new_frame_in, game_over_in, player_won_in, button_in,
    input  game_color_in, win_color_in, lose_color_in,
    output color_out, screen_sel_out, game_freeze_out, restart_out
  );
endinterface

// File: rtl/end_screen_controller.sv
// Sequences gameplay -> freeze -> win/lose end screen -> armed restart -> new round,
// and muxes the registered output pixel between gameplay and end-screen layers.
module end_screen_controller #(
  parameter int unsigned FREEZE_FRAMES   = 60,
  parameter int unsigned MIN_SHOW_FRAMES = 90,
  parameter int unsigned BLINK_FRAMES    = 30
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  end_screen_controller_if.slave   bus
);

  localparam int unsigned MAX_AB = (FREEZE_FRAMES > MIN_SHOW_FRAMES) ? FREEZE_FRAMES : MIN_SHOW_FRAMES;
  localparam int unsigned MAX_P  = (MAX_AB > BLINK_FRAMES) ? MAX_AB : BLINK_FRAMES;
  localparam int unsigned CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] FREEZE_LAST = CW'(FREEZE_FRAMES - 1);
  localparam logic [CW-1:0] SHOW_LAST   = CW'(MIN_SHOW_FRAMES - 1);
  localparam logic [CW-1:0] BLINK_LAST  = CW'(BLINK_FRAMES - 1);

  localparam logic [2:0] S_PLAY    = 3'd0;
  localparam logic [2:0] S_FREEZE  = 3'd1;
  localparam logic [2:0] S_SHOW    = 3'd2;
  localparam logic [2:0] S_ARMED   = 3'd3;
  localparam logic [2:0] S_RESTART = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic          won_q, won_d;
  logic          go_q, btn_q;
  logic          go_valid_q;
  logic [23:0]   color_q, color_d;
  logic [1:0]    sel_q, sel_d;
  logic          freeze_q, freeze_d;
  logic          restart_q, restart_d;

  logic          go_rise, btn_rise;
  logic [23:0]   end_pix;

  // go_q is cleared by reset, so a game_over level already high at reset release
  // would look like an edge; go_valid_q suppresses that first sample.
  assign go_rise  = bus.game_over_in & ~go_q & go_valid_q;
  assign btn_rise = bus.button_in & ~btn_q;
  assign end_pix  = won_q ? bus.win_color_in : bus.lose_color_in;

  function automatic logic [23:0] dim(input logic [23:0] c);
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
  endfunction

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    won_d       = won_q;
    case (state_q)
      S_PLAY: begin
        if (go_rise) begin
          state_d     = S_FREEZE;
          won_d       = bus.player_won_in;
          frame_cnt_d = '0;
        end
      end
      S_FREEZE: begin
        if (bus.new_frame_in) begin
          if (frame_cnt_q == FREEZE_LAST) begin
            state_d     = S_SHOW;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_SHOW: begin
        if (bus.new_frame_in) begin
          if (frame_cnt_q == SHOW_LAST) begin
            state_d     = S_ARMED;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (bus.new_frame_in) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
        if (btn_rise) state_d = S_RESTART;
      end
      S_RESTART: state_d = S_PLAY;
      default:   state_d = S_PLAY;
    endcase
  end

  always_comb begin
    sel_d     = 2'd0;
    freeze_d  = 1'b0;
    restart_d = 1'b0;
    color_d   = bus.game_color_in;
    case (state_q)
      S_FREEZE: freeze_d = 1'b1;
      S_SHOW, S_ARMED: begin
        sel_d    = won_q ? 2'd1 : 2'd2;
        freeze_d = 1'b1;
        if (end_pix == '0)
          color_d = dim(bus.game_color_in);
        else if ((state_q == S_ARMED) && blink_ph_q)
          color_d = dim(end_pix);
        else
          color_d = end_pix;
      end
      S_RESTART: restart_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_PLAY;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      won_q       <= 1'b0;
      go_q        <= 1'b0;
      btn_q       <= 1'b0;
      go_valid_q  <= 1'b0;
      color_q     <= '0;
      sel_q       <= '0;
      freeze_q    <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      won_q       <= won_d;
      go_q        <= bus.game_over_in;
      btn_q       <= bus.button_in;
      go_valid_q  <= 1'b1;
      color_q     <= color_d;
      sel_q       <= sel_d;
      freeze_q    <= freeze_d;
      restart_q   <= restart_d;
    end
  end

  assign bus.color_out       = color_q;
  assign bus.screen_sel_out  = sel_q;
  assign bus.game_freeze_out = freeze_q;
  assign bus.restart_out     = restart_q;

endmodule

// File: tb/tb_end_screen_controller.sv
// Directed bench for end_screen_controller: round sequencing, pixel mux, blink and restart.
module tb_end_screen_controller;
  logic clk_in = 1'b0;
  logic rst_n_in;
  int   tests = 0;
  int   fails = 0;
  logic saw_restart;

  end_screen_controller_if bus ();

  end_screen_controller #(
    .FREEZE_FRAMES  (60),
    .MIN_SHOW_FRAMES(90),
    .BLINK_FRAMES   (30)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (bus.restart_out === 1'b1) saw_restart = 1'b1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.new_frame_in = 1'b1;
      tick();
      bus.new_frame_in = 1'b0;
      tick();
    end
  endtask

  task automatic apply_reset();
    rst_n_in = 1'b0;
    bus.game_over_in = 1'b0;
    bus.button_in    = 1'b0;
    bus.new_frame_in = 1'b0;
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();
    tick();
  endtask

  task automatic start_round(input logic won);
    bus.player_won_in = won;
    bus.game_over_in  = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (bus.screen_sel_out !== 2'd0 || bus.game_freeze_out !== 1'b0 || bus.restart_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: sel=%0d freeze=%b restart=%b, required 0/0/0",
               bus.screen_sel_out, bus.game_freeze_out, bus.restart_out);
    end
    tests++;
    if (bus.color_out !== bus.game_color_in) begin
      fails++;
      $display("FAIL reset_play_pixel: color=%h, required %h", bus.color_out, bus.game_color_in);
    end
  endtask

  task automatic test_freeze_win();
    start_round(1'b1);
    tests++;
    if (bus.game_freeze_out !== 1'b1 || bus.screen_sel_out !== 2'd0) begin
      fails++;
      $display("FAIL freeze_entry: freeze=%b sel=%0d, required 1/0", bus.game_freeze_out, bus.screen_sel_out);
    end
    frames(59);
    tests++;
    if (bus.screen_sel_out !== 2'd0) begin
      fails++;
      $display("FAIL freeze_59_frames: sel=%0d, required 0", bus.screen_sel_out);
    end
    frames(1);
    tests++;
    if (bus.screen_sel_out !== 2'd1 || bus.game_freeze_out !== 1'b1) begin
      fails++;
      $display("FAIL win_screen: sel=%0d freeze=%b, required 1/1", bus.screen_sel_out, bus.game_freeze_out);
    end
  endtask

  task automatic test_lose_pixel();
    apply_reset();
    start_round(1'b0);
    frames(60);
    bus.win_color_in  = 24'hFFFFFF;
    bus.lose_color_in = 24'h00FF00;
    bus.game_color_in = 24'h123456;
    tick();
    tests++;
    if (bus.screen_sel_out !== 2'd2) begin
      fails++;
      $display("FAIL lose_sel: sel=%0d, required 2", bus.screen_sel_out);
    end
    tests++;
    if (bus.color_out !== 24'h00FF00) begin
      fails++;
      $display("FAIL lose_pixel: color=%h, required 00ff00", bus.color_out);
    end
  endtask

  task automatic test_transparent_dim();
    bus.lose_color_in = 24'h000000;
    bus.game_color_in = 24'h804020;
    tick();
    tests++;
    if (bus.color_out !== 24'h402010) begin
      fails++;
      $display("FAIL dim_background: color=%h, required 402010", bus.color_out);
    end
  endtask

  task automatic test_restart();
    saw_restart = 1'b0;
    bus.button_in = 1'b1;
    frames(89);
    frames(1);
    repeat (5) tick();
    tests++;
    if (saw_restart !== 1'b0) begin
      fails++;
      $display("FAIL held_button_no_restart: restart seen=%b, required 0", saw_restart);
    end
    bus.button_in = 1'b0;
    tick();
    bus.button_in = 1'b1;
    tick();
    tests++;
    if (bus.restart_out !== 1'b0) begin
      fails++;
      $display("FAIL restart_latency: restart=%b, required 0", bus.restart_out);
    end
    tick();
    tests++;
    if (bus.restart_out !== 1'b1 || bus.screen_sel_out !== 2'd0 || bus.game_freeze_out !== 1'b0) begin
      fails++;
      $display("FAIL restart_pulse: restart=%b sel=%0d freeze=%b, required 1/0/0",
               bus.restart_out, bus.screen_sel_out, bus.game_freeze_out);
    end
    tick();
    tests++;
    if (bus.restart_out !== 1'b0) begin
      fails++;
      $display("FAIL restart_single_cycle: restart=%b, required 0", bus.restart_out);
    end
    bus.button_in = 1'b0;
    repeat (4) tick();
    tests++;
    if (bus.game_freeze_out !== 1'b0 || bus.screen_sel_out !== 2'd0) begin
      fails++;
      $display("FAIL held_game_over_no_retrigger: freeze=%b sel=%0d, required 0/0",
               bus.game_freeze_out, bus.screen_sel_out);
    end
  endtask

  task automatic test_blink();
    bus.game_over_in = 1'b0;
    tick();
    start_round(1'b0);
    frames(60);
    frames(90);
    bus.lose_color_in = 24'hF46305;
    tick();
    tests++;
    if (bus.color_out !== 24'hF46305) begin
      fails++;
      $display("FAIL armed_bright: color=%h, required f46305", bus.color_out);
    end
    frames(29);
    tests++;
    if (bus.color_out !== 24'hF46305) begin
      fails++;
      $display("FAIL blink_29_frames: color=%h, required f46305", bus.color_out);
    end
    frames(1);
    tests++;
    if (bus.color_out !== 24'h7A3102) begin
      fails++;
      $display("FAIL blink_dim: color=%h, required 7a3102", bus.color_out);
    end
    frames(30);
    tests++;
    if (bus.color_out !== 24'hF46305) begin
      fails++;
      $display("FAIL blink_back: color=%h, required f46305", bus.color_out);
    end
  endtask

  task automatic test_reset_mid_show();
    apply_reset();
    start_round(1'b1);
    frames(60);
    bus.win_color_in = 24'hABCDEF;
    tick();
    #2;
    rst_n_in = 1'b0;
    #1;
    tests++;
    if (bus.screen_sel_out !== 2'd0 || bus.game_freeze_out !== 1'b0 ||
        bus.color_out !== 24'h0 || bus.restart_out !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: sel=%0d freeze=%b color=%h restart=%b, required all 0",
               bus.screen_sel_out, bus.game_freeze_out, bus.color_out, bus.restart_out);
    end
    tick();
    rst_n_in = 1'b1;
    saw_restart = 1'b0;
    repeat (10) tick();
    tests++;
    if (bus.screen_sel_out !== 2'd0 || bus.game_freeze_out !== 1'b0 || saw_restart !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_stays_play: sel=%0d freeze=%b restart_seen=%b, required 0/0/0",
               bus.screen_sel_out, bus.game_freeze_out, saw_restart);
    end
    bus.game_over_in = 1'b0;
    tick();
    start_round(1'b0);
    tests++;
    if (bus.game_freeze_out !== 1'b1) begin
      fails++;
      $display("FAIL new_edge_triggers: freeze=%b, required 1", bus.game_freeze_out);
    end
  endtask

  initial begin
    rst_n_in          = 1'b0;
    saw_restart       = 1'b0;
    bus.new_frame_in  = 1'b0;
    bus.game_over_in  = 1'b0;
    bus.player_won_in = 1'b0;
    bus.button_in     = 1'b0;
    bus.game_color_in = 24'h204080;
    bus.win_color_in  = 24'h0000FF;
    bus.lose_color_in = 24'hFF0000;
    test_reset();
    test_freeze_win();
    test_lose_pixel();
    test_transparent_dim();
    test_restart();
    test_blink();
    test_reset_mid_show();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
